glow_v1_muldiv_seq: RTL and testbench

//  Sequencer for the Glow v1 ALU's multicycle ops: 0x0f MULLO, 0x10 MULHI, 0x11 DIV, 0x12 MOD.

---
 rtl/glow_v1_pkg.sv | 24 ++
 rtl/glow_v1_muldiv_dp.sv | 61 ++++++
 rtl/glow_v1_muldiv_seq.sv | 120 ++++++++++++
 tb/tb_glow_v1_muldiv_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/glow_v1_pkg.sv
// rtl/glow_v1_pkg.sv - shared Glow v1 ALU opcodes, multicycle FSM states and opcode helpers
package glow_v1_pkg;

    localparam logic [4:0] OP_MULLO = 5'h0f;
    localparam logic [4:0] OP_MULHI = 5'h10;
    localparam logic [4:0] OP_DIV   = 5'h11;
    localparam logic [4:0] OP_MOD   = 5'h12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Also used by the ALU's OpFinish mux to pick the sequencer's done.
    function automatic logic is_multicycle(input logic [4:0] op);
        return (op >= OP_MULLO) && (op <= OP_MOD);
    endfunction

    function automatic logic is_divide(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/glow_v1_muldiv_dp.sv
// rtl/glow_v1_muldiv_dp.sv - shared shift register, operand register and W+1-bit add/sub for mul/div
module glow_v1_muldiv_dp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);
    import glow_v1_pkg::*;

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH:0]     add_sum;
    logic               add_cin;

    // Multiply keeps the multiplier in the low half and shifts it out, so the
    // operand register holds A; divide keeps the divisor there instead.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (mode_div) begin
            add_a   = acc_q[2*WIDTH-1:WIDTH-1];
            add_b   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_b = acc_q[0] ? {1'b0, opnd_q} : '0;
        end
        add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc_q  <= mode_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opnd_q <= mode_div ? b : a;
        end else if (step) begin
            if (!mode_div) begin
                acc_q <= {add_sum, acc_q[WIDTH-1:1]};
            end else if (!add_sum[WIDTH]) begin
                // No borrow: shifted remainder >= divisor, keep difference and set quotient bit.
                acc_q <= {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_q <= {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/glow_v1_muldiv_seq.sv
// rtl/glow_v1_muldiv_seq.sv - multicycle MULLO/MULHI/DIV/MOD sequencer; GLOW_MULDIV_FAST_ZERO_EN enables zero-operand bypass
module glow_v1_muldiv_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] dsrc_a,
    input  logic [WIDTH-1:0] dsrc_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);
    import glow_v1_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         op_q;
    logic               bz_q;
    logic               accept;
    logic               skip;
    logic               mode_div;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   res_sel;

    assign accept   = (state_q == IDLE) && start && is_multicycle(opcode);
    assign mode_div = accept ? is_divide(opcode) : is_divide(op_q);
    assign busy     = (state_q == RUN);
    assign acc_lo   = acc[WIDTH-1:0];
    assign acc_hi   = acc[2*WIDTH-1:WIDTH];

`ifdef GLOW_MULDIV_FAST_ZERO_EN
    logic skip_q;
    assign skip = (dsrc_b == '0) || (!is_divide(opcode) && (dsrc_a == '0));
`else
    assign skip = 1'b0;
`endif

    glow_v1_muldiv_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state_q == RUN),
        .mode_div (mode_div),
        .a        (dsrc_a),
        .b        (dsrc_b),
        .acc      (acc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = skip ? DONE : RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full restoring run with B==0 already leaves all-ones / A; the explicit
    // forcing keeps the bypassed (unshifted) case correct too.
    always_comb begin
        res_sel = acc_lo;
        case (op_q)
            OP_MULLO: res_sel = acc_lo;
            OP_MULHI: res_sel = acc_hi;
            OP_DIV:   res_sel = bz_q ? '1 : acc_lo;
            OP_MOD:   res_sel = acc_hi;
            default:  res_sel = acc_lo;
        endcase
`ifdef GLOW_MULDIV_FAST_ZERO_EN
        if (skip_q) begin
            if (!is_divide(op_q))   res_sel = '0;
            else if (op_q == OP_MOD) res_sel = acc_lo;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            bz_q    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            dz      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == DONE);
            if (accept) begin
                op_q  <= opcode;
                bz_q  <= is_divide(opcode) && (dsrc_b == '0);
                dz    <= 1'b0;
                cnt_q <= '0;
            end
            if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == DONE) begin
                result <= res_sel;
                dz     <= bz_q;
            end
        end
    end

`ifdef GLOW_MULDIV_FAST_ZERO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         skip_q <= 1'b0;
        else if (accept) skip_q <= skip;
    end
`endif

endmodule

// File: tb/tb_glow_v1_muldiv_seq.sv
// tb/tb_glow_v1_muldiv_seq.sv - directed-vector bench for glow_v1_muldiv_seq
module tb_glow_v1_muldiv_seq;

    localparam int WIDTH = 8;
`ifdef GLOW_MULDIV_FAST_ZERO_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 9;
    localparam int ZERO_BUSY = 8;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] dsrc_a;
    logic [WIDTH-1:0] dsrc_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             dz;

    int vectors     = 0;
    int miscompares = 0;

    glow_v1_muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .dsrc_a (dsrc_a),
        .dsrc_b (dsrc_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        dsrc_a = a;
        dsrc_b = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = busy ? 1 : 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_res, input logic exp_dz,
                         input int exp_lat, input int exp_busy);
        int lat, busy_n;
        start_op(op, a, b);
        wait_done(lat, busy_n);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_busy"}, busy_n, exp_busy);
        check_eq({tag, "_res"}, {24'd0, result}, {24'd0, exp_res});
        check_eq({tag, "_dz"}, {31'd0, dz}, {31'd0, exp_dz});
    endtask

    initial begin
        int lat, busy_n, seen;
        rst    = 1'b1;
        start  = 1'b0;
        opcode = '0;
        dsrc_a = '0;
        dsrc_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_res", {24'd0, result}, 0);
        check_eq("rst_dz", {31'd0, dz}, 0);
        @(negedge clk) rst = 1'b0;

        // 1: full-width multiply, latency and single-cycle done
        do_op("mullo_ff", 5'h0f, 8'hFF, 8'hFF, 8'h01, 1'b0, 9, 8);
        @(posedge clk);
        #1 check_eq("done_pulse", {31'd0, done}, 0);
        check_eq("res_held", {24'd0, result}, 32'h01);
        do_op("mulhi_ff", 5'h10, 8'hFF, 8'hFF, 8'hFE, 1'b0, 9, 8);

        // 2: divide / modulo
        do_op("div_200_7", 5'h11, 8'd200, 8'd7, 8'h1C, 1'b0, 9, 8);
        do_op("mod_200_7", 5'h12, 8'd200, 8'd7, 8'h04, 1'b0, 9, 8);
        do_op("div_5_9", 5'h11, 8'h05, 8'h09, 8'h00, 1'b0, 9, 8);
        do_op("mod_5_9", 5'h12, 8'h05, 8'h09, 8'h05, 1'b0, 9, 8);

        // 3: divide by zero, then dz clears on a multiply
        do_op("div_z", 5'h11, 8'h55, 8'h00, 8'hFF, 1'b1, ZERO_LAT, ZERO_BUSY);
        do_op("mod_z", 5'h12, 8'h55, 8'h00, 8'h55, 1'b1, ZERO_LAT, ZERO_BUSY);
        do_op("mullo_3_4", 5'h0f, 8'h03, 8'h04, 8'h0C, 1'b0, 9, 8);

        // 4: start while busy is ignored
        start_op(5'h10, 8'hFF, 8'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        opcode = 5'h11;
        dsrc_a = 8'h10;
        dsrc_b = 8'h02;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, busy_n);
        check_eq("ign_lat", lat, 6);
        check_eq("ign_res", {24'd0, result}, 32'hFE);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (busy || done) seen++;
        end
        check_eq("ign_no_rerun", seen, 0);

        // 4b: non-multicycle opcode ignored in IDLE
        start_op(5'h05, 8'h12, 8'h34);
        seen = (busy || done) ? 1 : 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (busy || done) seen++;
        end
        check_eq("bad_op_quiet", seen, 0);

        // 5: async reset mid-run
        start_op(5'h0f, 8'h10, 8'h10);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", {31'd0, busy}, 0);
        check_eq("mid_rst_done", {31'd0, done}, 0);
        check_eq("mid_rst_res", {24'd0, result}, 0);
        check_eq("mid_rst_dz", {31'd0, dz}, 0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        check_eq("mid_rst_no_done", seen, 0);
        do_op("post_mullo", 5'h0f, 8'h10, 8'h10, 8'h00, 1'b0, 9, 8);
        do_op("post_mulhi", 5'h10, 8'h10, 8'h10, 8'h01, 1'b0, 9, 8);

        // 6: zero multiplicand
        do_op("mullo_zero", 5'h0f, 8'h00, 8'h37, 8'h00, 1'b0, ZERO_LAT, ZERO_BUSY);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
